// File: rtl/cacheline_adapter.sv
// Bridges a full-line cache request onto a multi-beat memory burst, assembling
// read beats into a line and slicing a latched line into write beats.
module cacheline_adapter #(
    parameter int s_line = 256,
    parameter int s_beat = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int NBEATS = s_line / s_beat;
    localparam int CW     = $clog2(NBEATS);
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [31:0]                  addr_q, addr_d;
    logic [NBEATS-1:0][s_beat-1:0] wline_q, wline_d;
    logic [NBEATS-1:0][s_beat-1:0] rline_q, rline_d;

    // Write takes priority at acceptance; a stalled beat (burst_resp low) changes nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    state_d = WRITE;
                    addr_d  = pmem_address & 32'hFFFF_FFE0;
                    wline_d = pmem_wdata;
                    cnt_d   = '0;
                end else if (pmem_read) begin
                    state_d = READ;
                    addr_d  = pmem_address & 32'hFFFF_FFE0;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (burst_resp) begin
                    rline_d[cnt_q] = burst_rdata;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // The read line stays visible after DONE until the next read overwrites beat 0.
    assign pmem_rdata    = rline_q;
    assign pmem_resp     = (state_q == DONE);
    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign burst_address = (burst_read || burst_write) ? addr_q : 32'd0;
    assign burst_wdata   = burst_write ? wline_q[cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: expected lines/beats are queued when a
// request is driven and compared when the adapter produces them.
module tb_cacheline_adapter;

    localparam int S_LINE = 256;
    localparam int S_BEAT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              burst_read;
    logic              burst_write;
    logic [31:0]       burst_address;
    logic [S_BEAT-1:0] burst_wdata;
    logic [S_BEAT-1:0] burst_rdata;
    logic              burst_resp;

    int compared   = 0;
    int mismatched = 0;

    logic [S_LINE-1:0] lineQ[$];
    logic [S_BEAT-1:0] beatQ[$];
    logic [S_LINE-1:0] lastLine;

    cacheline_adapter #(.s_line(S_LINE), .s_beat(S_BEAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request, serves the burst per respMask (bit c = resp in cycle c after acceptance).
    task automatic applyStimulus(input bit doWrite, input bit doRead, input logic [31:0] addr,
                                 input logic [S_LINE-1:0] wdata, input logic [S_LINE-1:0] mem,
                                 input logic [31:0] respMask, input logic [31:0] expAddr,
                                 input int expCycle, input bit scramble);
        bit done;
        int bi;
        logic [S_LINE-1:0] expLine;
        expLine      = '0;
        pmem_write   = doWrite;
        pmem_read    = doRead;
        pmem_address = addr;
        pmem_wdata   = wdata;
        if (doWrite) begin
            for (int i = 0; i < S_LINE / S_BEAT; i++) beatQ.push_back(S_BEAT'(wdata >> (i * S_BEAT)));
        end else begin
            lineQ.push_back(mem);
        end
        tick();
        pmem_write = 1'b0;
        pmem_read  = 1'b0;
        if (scramble) begin
            pmem_address = ~addr;
            pmem_wdata   = ~wdata;
        end
        done = 1'b0;
        bi   = 0;
        for (int c = 1; c <= 30 && !done; c++) begin
            if (pmem_resp) begin
                done = 1'b1;
                checkOutput("respCycle", S_LINE'(c), S_LINE'(expCycle));
                checkOutput("rwLowInDone", {burst_read, burst_write}, '0);
                checkOutput("addrZeroInDone", burst_address, '0);
                if (!doWrite) begin
                    if (lineQ.size() > 0) expLine = lineQ.pop_front();
                    else checkOutput("lineQEmpty", 1, 0);
                    checkOutput("rdata", pmem_rdata, expLine);
                    lastLine = expLine;
                end
                tick();
                checkOutput("respOnePulse", pmem_resp, 0);
                if (!doWrite) checkOutput("rdataHeld", pmem_rdata, expLine);
            end else begin
                checkOutput("burstRead", burst_read, !doWrite);
                checkOutput("burstWrite", burst_write, doWrite);
                checkOutput("burstAddr", burst_address, expAddr);
                burst_resp  = respMask[c];
                burst_rdata = S_BEAT'(mem >> (bi * S_BEAT));
                if (burst_resp) begin
                    if (doWrite) begin
                        if (beatQ.size() > 0) checkOutput("wbeat", burst_wdata, beatQ.pop_front());
                        else checkOutput("extraWriteBeat", 1, 0);
                    end
                    bi++;
                end
                tick();
                burst_resp = 1'b0;
            end
        end
        if (!done) checkOutput("respTimeout", 0, 1);
        beatQ.delete();
    endtask

    initial begin
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        lastLine     = '0;
        tick();
        tick();
        checkOutput("rstResp", pmem_resp, 0);
        checkOutput("rstRead", burst_read, 0);
        checkOutput("rstWrite", burst_write, 0);
        checkOutput("rstAddr", burst_address, 0);
        checkOutput("rstWdata", burst_wdata, 0);
        checkOutput("rstRdata", pmem_rdata, 0);
        rst = 1'b0;

        // Read with a response every cycle.
        applyStimulus(1'b0, 1'b1, 32'h0000_1234, {4{64'h5A5A_0F0F_1234_9876}},
                      {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                      32'h0000_001E, 32'h0000_1220, 5, 1'b0);

        // Write with stalls: resp in cycles 2, 4, 5 and 9.
        applyStimulus(1'b1, 1'b0, 32'h0000_2008,
                      {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                      '0, 32'h0000_0234, 32'h0000_2000, 10, 1'b0);
        checkOutput("rdataKeptAcrossWrite", pmem_rdata, lastLine);

        // Read and write together: write wins.
        applyStimulus(1'b1, 1'b1, 32'hABCD_EF5F,
                      {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0},
                      '1, 32'h0000_001E, 32'hABCD_EF40, 5, 1'b0);

        // Reset after two read beats.
        pmem_read    = 1'b1;
        pmem_address = 32'h4000_0010;
        tick();
        pmem_read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hEEEE_0000_0000_0000 | 64'(i);
            tick();
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("abortRead", burst_read, 0);
        checkOutput("abortResp", pmem_resp, 0);
        checkOutput("abortAddr", burst_address, 0);
        checkOutput("abortRdata", pmem_rdata, 0);
        tick();
        checkOutput("abortRespHold", pmem_resp, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h4000_0010, '0,
                      {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
                       64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000},
                      32'h0000_001E, 32'h4000_0000, 5, 1'b0);

        // Spurious responses while idle.
        for (int i = 0; i < 3; i++) begin
            burst_resp = 1'b1;
            tick();
            checkOutput("idleSpurious", {pmem_resp, burst_read, burst_write}, 0);
        end
        burst_resp = 1'b0;
        checkOutput("idleRdataKept", pmem_rdata,
                    {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
                     64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000});

        // Read with the request address changed mid-burst and stalls in between.
        applyStimulus(1'b0, 1'b1, 32'h0000_7FFF, '0,
                      {64'h0000_0000_DEAD_BEEF, 64'h0000_0000_CAFE_F00D,
                       64'h0000_0000_1234_5678, 64'h0000_0000_9ABC_DEF0},
                      32'h0000_005A, 32'h0000_7FE0, 7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
